// File: rtl/qpu_ifu_irstage.sv
// qpu_ifu_irstage: fetch FSM with at most one ITCM fetch in flight, feeding a single IR register to the EXU.
// Optional static branch prediction is compiled in when QPU_IFU_BPU_EN is defined.
`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif
`ifndef QPU_INSTR_SIZE
`define QPU_INSTR_SIZE 32
`endif
`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif

module qpu_ifu_irstage #(
  parameter logic [`QPU_PC_SIZE-1:0] RESET_PC = {`QPU_PC_SIZE{1'b0}}
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             ifu_active,
  output logic                             ifu_icb_cmd_valid,
  input  logic                             ifu_icb_cmd_ready,
  output logic [`QPU_PC_SIZE-1:0]          ifu_icb_cmd_addr,
  input  logic                             ifu_icb_rsp_valid,
  output logic                             ifu_icb_rsp_ready,
  input  logic [`QPU_INSTR_SIZE-1:0]       ifu_icb_rsp_rdata,
  output logic                             ifu_o_valid,
  input  logic                             ifu_o_ready,
  output logic [`QPU_INSTR_SIZE-1:0]       ifu_o_ir,
  output logic [`QPU_PC_SIZE-1:0]          ifu_o_pc,
  output logic                             ifu_o_prdt_taken,
  output logic [`QPU_RFIDX_REAL_WIDTH-1:0] ifu_o_rs1idx,
  output logic [`QPU_RFIDX_REAL_WIDTH-1:0] ifu_o_rs2idx,
  input  logic                             pipe_flush_req,
  output logic                             pipe_flush_ack,
  input  logic [`QPU_PC_SIZE-1:0]          pipe_flush_add_op1,
  input  logic [`QPU_PC_SIZE-1:0]          pipe_flush_add_op2
);

  localparam int PCW = `QPU_PC_SIZE;
  localparam int IRW = `QPU_INSTR_SIZE;
  localparam logic [PCW-1:0] PC_STEP = {{(PCW-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e         state_q;
  logic [PCW-1:0] fetch_pc_q;
  logic [IRW-1:0] ir_q;
  logic [PCW-1:0] pc_q;
  logic           prdt_q;
  logic           ir_valid_q;

  logic           ir_hsk_s;
  logic           cmd_hsk_s;
  logic           flush_hsk_s;
  logic           rsp_load_s;
  logic [PCW-1:0] flush_pc_s;
  logic [PCW-1:0] nxt_pc_s;
  logic           prdt_taken_s;

  assign ifu_o_valid       = ir_valid_q & ~pipe_flush_req;
  assign ir_hsk_s          = ifu_o_valid & ifu_o_ready;
  // A new fetch may only start once the IR has room for its result.
  assign ifu_icb_cmd_valid = (state_q == ST_FETCH) & (~ir_valid_q | ir_hsk_s) & ~pipe_flush_req;
  assign ifu_icb_cmd_addr  = fetch_pc_q;
  assign cmd_hsk_s         = ifu_icb_cmd_valid & ifu_icb_cmd_ready;
  assign ifu_icb_rsp_ready = (state_q == ST_WAIT);
  assign pipe_flush_ack    = (state_q != ST_WAIT);
  assign flush_hsk_s       = pipe_flush_req & pipe_flush_ack;
  assign flush_pc_s        = pipe_flush_add_op1 + pipe_flush_add_op2;
  // A response landing while a redirect is pending belongs to the wrong path.
  assign rsp_load_s        = (state_q == ST_WAIT) & ifu_icb_rsp_valid & ~pipe_flush_req;
  assign ifu_active        = ~((state_q == ST_IDLE) & ~ir_valid_q);

  assign ifu_o_ir          = ir_q;
  assign ifu_o_pc          = pc_q;
  assign ifu_o_prdt_taken  = prdt_q;
  assign ifu_o_rs1idx      = ir_q[19:15];
  assign ifu_o_rs2idx      = ir_q[24:20];

`ifdef QPU_IFU_BPU_EN
  logic [6:0]     opc_s;
  logic           is_jal_s;
  logic           is_bxx_s;
  logic [PCW-1:0] jimm_s;
  logic [PCW-1:0] bimm_s;

  assign opc_s    = ifu_icb_rsp_rdata[6:0];
  assign is_jal_s = (opc_s == 7'b1101111);
  assign is_bxx_s = (opc_s == 7'b1100011);
  assign jimm_s   = {{(PCW-20){ifu_icb_rsp_rdata[31]}}, ifu_icb_rsp_rdata[19:12],
                     ifu_icb_rsp_rdata[20], ifu_icb_rsp_rdata[30:21], 1'b0};
  assign bimm_s   = {{(PCW-12){ifu_icb_rsp_rdata[31]}}, ifu_icb_rsp_rdata[7],
                     ifu_icb_rsp_rdata[30:25], ifu_icb_rsp_rdata[11:8], 1'b0};
  // Backward branches are predicted taken, forward ones not taken.
  assign prdt_taken_s = is_jal_s | (is_bxx_s & ifu_icb_rsp_rdata[31]);
  assign nxt_pc_s     = fetch_pc_q + (is_jal_s ? jimm_s : (prdt_taken_s ? bimm_s : PC_STEP));
`else
  assign prdt_taken_s = 1'b0;
  assign nxt_pc_s     = fetch_pc_q + PC_STEP;
`endif

  // Fetch FSM, IR register and fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      ir_q       <= {IRW{1'b0}};
      pc_q       <= {PCW{1'b0}};
      prdt_q     <= 1'b0;
      ir_valid_q <= 1'b0;
    end else if (flush_hsk_s) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= flush_pc_s;
      ir_valid_q <= 1'b0;
    end else begin
      if (rsp_load_s) begin
        ir_q       <= ifu_icb_rsp_rdata;
        pc_q       <= fetch_pc_q;
        prdt_q     <= prdt_taken_s;
        fetch_pc_q <= nxt_pc_s;
        ir_valid_q <= 1'b1;
      end else if (ir_hsk_s) begin
        ir_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE:  state_q <= ST_FETCH;
        ST_FETCH: if (cmd_hsk_s) state_q <= ST_WAIT;
        ST_WAIT:  if (ifu_icb_rsp_valid) state_q <= ST_FETCH;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/qpu_ifu_irstage.md
QPU_IFU_IRSTAGE -- requirements
Module: qpu_ifu_irstage

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port ifu_active  out  1  high unless in IDLE with IR empty.
REQ-005 SHALL have ports ifu_icb_cmd_valid out 1, ifu_icb_cmd_ready in 1, ifu_icb_cmd_addr out `QPU_PC_SIZE: ITCM fetch command.
REQ-006 SHALL have ports ifu_icb_rsp_valid in 1, ifu_icb_rsp_ready out 1, ifu_icb_rsp_rdata in `QPU_INSTR_SIZE: ITCM fetch response.
REQ-007 SHALL have ports ifu_o_valid out 1, ifu_o_ready in 1, ifu_o_ir out `QPU_INSTR_SIZE, ifu_o_pc out `QPU_PC_SIZE, ifu_o_prdt_taken out 1: IR handoff to EXU.
REQ-008 SHALL have ports ifu_o_rs1idx, ifu_o_rs2idx out `QPU_RFIDX_REAL_WIDTH each: ir[19:15], ir[24:20].
REQ-009 SHALL have ports pipe_flush_req in 1, pipe_flush_ack out 1, pipe_flush_add_op1 in `QPU_PC_SIZE, pipe_flush_add_op2 in `QPU_PC_SIZE: EXU redirect.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, WAIT; at most one fetch outstanding.
REQ-011 IDLE: SHALL go to FETCH one cycle after rst_n deasserts, fetch PC = RESET_PC.
REQ-012 FETCH: SHALL assert cmd_valid, addr = fetch PC, when IR empty or IR handshaking this cycle; cmd_valid&cmd_ready -> WAIT.
REQ-013 WAIT: rsp_ready SHALL be 1; rsp_valid -> load IR/PC, set ir_valid, compute next fetch PC, go FETCH.
REQ-014 ifu_o_valid SHALL equal ir_valid & ~pipe_flush_req; ir_valid clears on ifu_o_valid&ifu_o_ready unless reloaded same cycle.
REQ-015 Next fetch PC SHALL be pc+4 (mod 2^`QPU_PC_SIZE, wrap without error) unless prediction taken (REQ-020).
REQ-016 pipe_flush_ack SHALL be 1 in IDLE and FETCH, 0 in WAIT.
REQ-017 On pipe_flush_req&ack: ir_valid SHALL clear, fetch PC = add_op1+add_op2 (carry dropped), FSM = FETCH next cycle; no cmd issued that cycle.
REQ-018 Flush arriving in WAIT: response SHALL be discarded (not loaded into IR) when it arrives while flush_req held; ack rises in FETCH.
REQ-019 Flush simultaneous with cmd handshake: flush SHALL win; cmd_valid gated low whenever pipe_flush_req is high.

Reset
REQ-021 On rst_n low: FSM = IDLE, ir_valid = 0, ifu_o_ir = 0, ifu_o_pc = 0, ifu_o_prdt_taken = 0, fetch PC = RESET_PC, cmd_valid = 0, rsp_ready = 0, asynchronously.
REQ-022 Reset mid-WAIT SHALL abandon the outstanding fetch; a late rsp_valid after reset SHALL be ignored (rsp_ready = 0 outside WAIT).

Configuration
REQ-020 With QPU_IFU_BPU_EN defined: static prediction -- opcode 1101111 (JAL) taken, target pc+J-imm; opcode 1100011 (branch) taken iff B-imm negative, target pc+B-imm; ifu_o_prdt_taken = 1 for taken.
REQ-023 Without QPU_IFU_BPU_EN: ifu_o_prdt_taken tied 0, next PC always pc+4, no immediate decoders synthesized.

Verification
REQ-024 Reset release, cmd_ready=1, rsp 1 cycle later, ifu_o_ready=1 -> addresses 0x0,0x4,0x8 fetched, ifu_o_pc matches, one instr per 2 cycles.
REQ-025 ifu_o_ready=0 for 5 cycles with IR full -> ifu_o_ir/pc stable, no cmd_valid; release -> next cmd same cycle.
REQ-026 Flush in FETCH, op1=0x100, op2=0x20 -> ack=1, IR invalid, next cmd addr 0x120.
REQ-027 Flush asserted in WAIT, rsp 3 cycles later -> ack 0 until rsp, IR not loaded, next cmd addr = op1+op2.
REQ-028 QPU_IFU_BPU_EN, instr at 0x40 = BEQ with offset -8 -> ifu_o_prdt_taken=1, next addr 0x38; offset +8 -> prdt 0, next 0x44; macro undefined -> 0x44 both.
REQ-029 Fetch PC 0xFFFFFFFC (32-bit) -> next addr wraps to 0x0; assert rst_n low in WAIT -> all outputs to reset values immediately.
